circular_fifo: RTL and testbench

Parametrised synchronous circular-buffer FIFO; generalises the fixed 4-bit × 16 linear FIFO to configurable width and depth, with pointer wrap-around, simultaneous read/write, an occupancy count, programmable almost-full/almost-empty thresholds and overflow/underflow error reporting. It is the standard single-clock buffer for datapath stages in this design and is a drop-in replacement for the linear FIFO at DATA_W=4, DEPTH=16.

---
 rtl/circular_fifo.sv | 128 ++++++++++++
 tb/tb_circular_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/circular_fifo.sv
// Single-clock circular-buffer FIFO with occupancy count, threshold flags
// and overflow/underflow reporting; define FIFO_STICKY_ERR_EN for sticky errors.
module circular_fifo #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      write_enb,
    input  logic                      read_enb,
    input  logic [DATA_W-1:0]         datain,
    input  logic                      clear_err,
    output logic [DATA_W-1:0]         dataout,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic full_w, empty_w;
    logic wr_acc, rd_acc;
    logic ov_evt, uf_evt;

    // Status comes from the count register only, never from the requests.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign rd_acc = read_enb && !empty_w;
    assign wr_acc = write_enb && (!full_w || rd_acc);

    assign ov_evt = write_enb && !wr_acc;
    assign uf_evt = read_enb && empty_w;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dataout_d = dataout_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            dataout_d = mem_q[rd_ptr_q];
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef FIFO_STICKY_ERR_EN
    // A new error in the clearing cycle keeps the flag set.
    always_comb begin
        overflow_d  = ov_evt || (overflow_q && !clear_err);
        underflow_d = uf_evt || (underflow_q && !clear_err);
    end
`else
    logic unused_clear_err;
    assign unused_clear_err = clear_err;

    always_comb begin
        overflow_d  = ov_evt;
        underflow_d = uf_evt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dataout_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dataout_q   <= dataout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

    assign dataout      = dataout_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_circular_fifo.sv
// Directed bench for circular_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_circular_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          write_enb;
    logic          read_enb;
    logic [DW-1:0] datain;
    logic          clear_err;
    logic [DW-1:0] dataout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    circular_fifo #(
        .DATA_W(DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_enb   (write_enb),
        .read_enb    (read_enb),
        .datain      (datain),
        .clear_err   (clear_err),
        .dataout     (dataout),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ov;
    logic          m_uf;
    logic          chk_en;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ov   = 1'b0;
        m_uf   = 1'b0;
    endtask

    task automatic model_step(input bit we, input bit re,
                              input logic [DW-1:0] d, input bit clr);
        bit rd_ok;
        bit wr_ok;
        bit ov_ev;
        bit uf_ev;
        rd_ok = re && (q.size() > 0);
        wr_ok = we && ((q.size() < DEPTH) || rd_ok);
        ov_ev = we && !wr_ok;
        uf_ev = re && (q.size() == 0);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
        m_ov = ov_ev || (m_ov && !clr);
        m_uf = uf_ev || (m_uf && !clr);
`else
        m_ov = ov_ev;
        m_uf = uf_ev;
        if (clr) m_ov = m_ov;
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit we, input bit re,
                       input logic [DW-1:0] d, input bit clr = 1'b0);
        write_enb = we;
        read_enb  = re;
        datain    = d;
        clear_err = clr;
        @(posedge clk);
        #1;
        model_step(we, re, d, clr);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("count", 32'(count), 32'(q.size()));
            check("full", 32'(full), 32'(q.size() == DEPTH));
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 2));
            check("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
            check("dataout", 32'(dataout), 32'(m_dout));
            check("overflow", 32'(overflow), 32'(m_ov));
            check("underflow", 32'(underflow), 32'(m_uf));
        end
    end

    initial begin
        chk_en    = 1'b0;
        rst_n     = 1'b0;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        datain    = '0;
        clear_err = 1'b0;
        model_reset();
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_dout", 32'(dataout), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill with 1..16; 16 wraps to 0 in four bits.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, DW'(i));
            if (i == 13) check("af_at_13", 32'(almost_full), 32'd0);
            if (i == 14) check("af_at_14", 32'(almost_full), 32'd1);
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_empty", 32'(empty), 32'd0);

        // Drain: expect 1..15 then 0.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, '0);
            check("drain_dout", 32'(dataout), 32'((i + 1) % 16));
            if (i == 12) check("ae_at_3", 32'(almost_empty), 32'd0);
            if (i == 13) check("ae_at_2", 32'(almost_empty), 32'd1);
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Overflow: fill with a pattern lacking 5, then try to write 5.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, (i % 2 == 1) ? 4'hC : 4'h3);
        end
        cyc(1'b1, 1'b0, 4'h5);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        cyc(1'b0, 1'b0, '0);
`ifdef FIFO_STICKY_ERR_EN
        check("ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'd0);
`else
        check("ovf_pulse", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, '0);
            check("ovf_no5", 32'(dataout == 4'h5), 32'd0);
        end

        // Full + read + write keeps count at DEPTH without overflow.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, DW'(i));
        cyc(1'b1, 1'b1, 4'hE);
        check("rw_full_count", 32'(count), 32'd16);
        check("rw_full_ovf", 32'(overflow), 32'd0);
        check("rw_full_dout", 32'(dataout), 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, '0);
        check("rw_full_last", 32'(dataout), 32'hE);

        // Empty + read + write: write lands, read rejected.
        cyc(1'b1, 1'b1, 4'h9);
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_count", 32'(count), 32'd1);
        check("udf_dout", 32'(dataout), 32'hE);
        cyc(1'b0, 1'b1, '0);
        check("udf_next", 32'(dataout), 32'h9);

        // Half full, then sustained read+write wraps pointers.
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, DW'(i));
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, DW'(9 + i));
            check("stream_count", 32'(count), 32'd8);
            check("stream_dout", 32'(dataout), 32'((i + 1) % 16));
        end

        // Asynchronous reset pulse between edges.
        write_enb = 1'b0;
        read_enb  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #0.5;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_dout", 32'(dataout), 32'd0);
        check("arst_af", 32'(almost_full), 32'd0);
        #0.5;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_empty", 32'(empty), 32'd1);
        cyc(1'b1, 1'b0, 4'h7);
        cyc(1'b0, 1'b1, '0);
        check("post_rst_dout", 32'(dataout), 32'h7);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
